// File: rtl/ev22_pkg.sv
// ev22_pkg: shared definitions for the EV22 fetch/execute sequencer.
//   state_t      - sequencer phases (FETCH/EXEC/MEM/WB)
//   OP_*         - opcode match constants for the control-flow group
//   IW_*         - field positions inside a 16-bit instruction word
//   is_ctrl_op() - true for opcodes the sequencer resolves itself
package ev22_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // Whole 001xxxxx block is control flow; JMP/JZE/JNE/JCY are selected by [4:3].
  localparam logic [2:0] OP_CF_CLASS = 3'b001;
  localparam logic [4:0] OP_JMP      = 5'b00100;
  localparam logic [4:0] OP_JZE      = 5'b00101;
  localparam logic [4:0] OP_JNE      = 5'b00110;
  localparam logic [4:0] OP_JCY      = 5'b00111;
  localparam logic [5:0] OP_BSR      = 6'b000111;
  localparam logic [7:0] OP_RET      = 8'b01000001;

  localparam int IW_OPC_MSB = 15;
  localparam int IW_OPC_LSB = 8;
  localparam int IW_OPD_MSB = 7;
  localparam int IW_OPD_LSB = 0;

  function automatic logic is_ctrl_op(input logic [7:0] op);
    return (op[7:5] == OP_CF_CLASS) || (op[7:2] == OP_BSR) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/ev22_ret_stack.sv
// ev22_ret_stack: subroutine return-address LIFO.
//   clk, rst         - clock, async active-high reset (empties the stack)
//   i_push, i_data   - push i_data; ignored when full
//   i_pop            - discard top entry; ignored when empty
//   o_top            - current top entry (valid when !o_empty)
//   o_full, o_empty  - occupancy flags
// Push and pop are never requested in the same cycle.
module ev22_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_sp;          // number of valid entries, 0..DEPTH
  logic [AW:0]  w_sp_m1;

  assign w_sp_m1 = r_sp - 1'b1;
  assign o_full  = (r_sp == (AW+1)'(DEPTH));
  assign o_empty = (r_sp == '0);
  assign o_top   = r_mem[w_sp_m1[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_sp <= w_sp_m1;
    end
  end

  // Storage needs no reset: entries are only read below the stack pointer.
  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_sp[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ev22_sequencer.sv
// ev22_sequencer: fetch/execute controller for the EV22 core.
// Owns pc, instruction register and the return stack; resolves
// JMP/JZE/JNE/JCY/BSR/RET locally and sequences data-memory handshakes.
//   clk, rst                    - clock, async active-high reset
//   imem_req/addr/ack/data      - instruction fetch port (addr = pc)
//   ir_opcode, ir_operand       - latched instruction fields to the decoder
//   dec_mr, dec_mw              - decoder memory read/write requests
//   w_zero, w_msb, cy           - status for conditional branches
//   dmem_req/we/ack             - data memory handshake
//   exec_en                     - one-cycle commit strobe for register writes
//   pc                          - program counter
//   stk_err                     - sticky return-stack overflow/underflow
module ev22_sequencer
  import ev22_pkg::*;
#(
  parameter int              PC_W        = 11,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [7:0]      ir_opcode,
  output logic [7:0]      ir_operand,
  input  logic            dec_mr,
  input  logic            dec_mw,
  input  logic            w_zero,
  input  logic            w_msb,
  input  logic            cy,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            exec_en,
  output logic [PC_W-1:0] pc,
  output logic            stk_err
);

  state_t          r_state, w_nstate;
  logic [PC_W-1:0] r_pc, w_npc;
  logic [7:0]      r_ir_opc, r_ir_opd;
  logic            r_stk_err, w_set_err;

  logic [PC_W-1:0] w_pc_inc, w_jmp_x, w_bsr_tgt, w_stk_top;
  logic            w_cf, w_is_jmp, w_is_bsr, w_is_ret, w_taken;
  logic            w_stk_full, w_stk_empty, w_push, w_pop;

  assign w_pc_inc  = r_pc + 1'b1;
  // 11-bit absolute target, zero-extended or truncated to the pc width.
  assign w_jmp_x   = PC_W'({r_ir_opc[2:0], r_ir_opd});
  // Relative BSR offset: the signed cast sign-extends the 8-bit operand.
  assign w_bsr_tgt = r_pc + PC_W'($signed(r_ir_opd));

  assign w_is_jmp = (r_ir_opc[7:5] == OP_CF_CLASS);
  assign w_is_bsr = (r_ir_opc[7:2] == OP_BSR);
  assign w_is_ret = (r_ir_opc == OP_RET);
  assign w_cf     = is_ctrl_op(r_ir_opc);

  always_comb begin
    w_taken = 1'b0;
    case (r_ir_opc[7:3])
      OP_JMP:  w_taken = 1'b1;
      OP_JZE:  w_taken = w_zero;
      OP_JNE:  w_taken = !w_msb;
      OP_JCY:  w_taken = cy;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_push = (r_state == ST_EXEC) && w_is_bsr;
  assign w_pop  = (r_state == ST_EXEC) && w_is_ret;

  ev22_ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stk (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_stk_top),
    .o_full  (w_stk_full),
    .o_empty (w_stk_empty)
  );

  always_comb begin
    w_nstate  = r_state;
    w_npc     = r_pc;
    w_set_err = 1'b0;
    case (r_state)
      ST_FETCH: if (imem_ack) w_nstate = ST_EXEC;
      ST_EXEC: begin
        if (w_cf) begin
          w_nstate = ST_FETCH;
          if (w_is_jmp) begin
            w_npc = w_taken ? w_jmp_x : w_pc_inc;
          end else if (w_is_bsr) begin
            // Overflow drops the return address but still takes the branch.
            w_set_err = w_stk_full;
            w_npc     = w_bsr_tgt;
          end else begin
            w_set_err = w_stk_empty;
            w_npc     = w_stk_empty ? w_pc_inc : w_stk_top;
          end
        end else if (dec_mr || dec_mw) begin
          w_nstate = ST_MEM;
        end else begin
          w_npc    = w_pc_inc;
          w_nstate = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          // Write takes priority; a read still needs the WB commit cycle.
          if (dec_mr && !dec_mw) begin
            w_nstate = ST_WB;
          end else begin
            w_npc    = w_pc_inc;
            w_nstate = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        w_npc    = w_pc_inc;
        w_nstate = ST_FETCH;
      end
      default: w_nstate = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_ir_opc  <= '0;
      r_ir_opd  <= '0;
      r_stk_err <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pc    <= w_npc;
      if (w_set_err) r_stk_err <= 1'b1;
      if (r_state == ST_FETCH && imem_ack) begin
        r_ir_opc <= imem_data[IW_OPC_MSB:IW_OPC_LSB];
        r_ir_opd <= imem_data[IW_OPD_MSB:IW_OPD_LSB];
      end
    end
  end

  // Strobes are gated by rst so they drop the instant reset asserts.
  assign imem_req   = !rst && (r_state == ST_FETCH);
  assign dmem_req   = !rst && (r_state == ST_MEM);
  assign dmem_we    = dmem_req && dec_mw;
  assign exec_en    = !rst && (((r_state == ST_EXEC) && !w_cf && !(dec_mr || dec_mw)) ||
                               (r_state == ST_WB));
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign ir_opcode  = r_ir_opc;
  assign ir_operand = r_ir_opd;
  assign stk_err    = r_stk_err;

endmodule

// File: tb/tb_ev22_sequencer.sv
module tb_ev22_sequencer;
  localparam int PC_W  = 11;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << PC_W) - 1;

  logic            clk, rst;
  logic            imem_req, imem_ack;
  logic [PC_W-1:0] imem_addr, pc;
  logic [15:0]     imem_data;
  logic [7:0]      ir_opcode, ir_operand;
  logic            dec_mr, dec_mw, w_zero, w_msb, cy;
  logic            dmem_req, dmem_we, dmem_ack, exec_en, stk_err;

  ev22_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir_opcode(ir_opcode), .ir_operand(ir_operand),
    .dec_mr(dec_mr), .dec_mw(dec_mw), .w_zero(w_zero), .w_msb(w_msb), .cy(cy),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .exec_en(exec_en), .pc(pc), .stk_err(stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_exec = 0;

  // Architectural model: pc, sticky error, return stack as a queue.
  int m_pc  = 0;
  bit m_err = 1'b0;
  bit m_we  = 1'b0;
  int m_stk[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_strobes", int'({imem_req, dmem_req, dmem_we, exec_en}), 0);
    end else begin
      if (exec_en) n_exec++;
      if (imem_req) begin
        chk("imem_addr", int'(imem_addr), m_pc);
        chk("pc", int'(pc), m_pc);
        chk("stk_err", int'(stk_err), int'(m_err));
      end
      if (dmem_req) chk("dmem_we", int'(dmem_we), int'(m_we));
    end
  end

  // Instruction-level effect on the model; returns expected exec pulses / mem use.
  task automatic model_step(input logic [7:0] op, input logic [7:0] opd,
                            input bit mr, input bit mw, input bit wz, input bit wm, input bit c,
                            output int e_exec, output int e_mem);
    int x, off;
    bit tk;
    x      = (int'(op[2:0]) * 256 + int'(opd)) & MASK;
    e_exec = 0;
    e_mem  = 0;
    m_we   = mw;
    if (op[7:5] == 3'b001) begin
      case (op[4:3])
        2'd0:    tk = 1'b1;
        2'd1:    tk = wz;
        2'd2:    tk = !wm;
        default: tk = c;
      endcase
      m_pc = tk ? x : (m_pc + 1) & MASK;
    end else if (op[7:2] == 6'b000111) begin
      if (m_stk.size() == DEPTH) m_err = 1'b1;
      else m_stk.push_back((m_pc + 1) & MASK);
      off  = (opd >= 8'd128) ? int'(opd) - 256 : int'(opd);
      m_pc = (m_pc + off) & MASK;
    end else if (op == 8'h41) begin
      if (m_stk.size() == 0) begin
        m_err = 1'b1;
        m_pc  = (m_pc + 1) & MASK;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else begin
      m_pc   = (m_pc + 1) & MASK;
      e_mem  = (mr || mw) ? 1 : 0;
      e_exec = mw ? 0 : 1;
    end
  endtask

  // Run one instruction: fetch with zero-wait ack, data ack after dly cycles.
  task automatic run(input logic [15:0] w, input bit mr, input bit mw,
                     input bit wz, input bit wm, input bit c, input int dly);
    int lat, dcnt, e_exec, e_mem, ex0;
    bit seen;
    imem_data = w; dec_mr = mr; dec_mw = mw; w_zero = wz; w_msb = wm; cy = c;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req;
    end
    chk("fetch_req_seen", int'(seen), 1);
    if (!seen) return;
    imem_ack = 1'b1;
    @(posedge clk);
    ex0 = n_exec;
    model_step(w[15:8], w[7:0], mr, mw, wz, wm, c, e_exec, e_mem);
    @(negedge clk);
    imem_ack = 1'b0;
    lat  = 1;
    dcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (imem_req) begin
        seen = 1'b1;
      end else begin
        lat++;
        if (dmem_req) begin
          dcnt++;
          dmem_ack = (dcnt >= dly);
        end else begin
          dmem_ack = 1'b0;
        end
        @(negedge clk);
      end
    end
    dmem_ack = 1'b0;
    chk("next_fetch_seen", int'(seen), 1);
    chk("latency", lat, (e_mem != 0) ? ((e_exec != 0) ? 3 + dly : 2 + dly) : 2);
    chk("exec_cnt", n_exec - ex0, e_exec);
    chk("dmem_cycles", dcnt, (e_mem != 0) ? dly : 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b0;
    dec_mr = 1'b0; dec_mw = 1'b0; w_zero = 1'b0; w_msb = 1'b0; cy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pc", int'(pc), 0);
    chk("rst_ir", int'({ir_opcode, ir_operand}), 0);
    chk("rst_stk_err", int'(stk_err), 0);
    #2 rst = 1'b0;

    // Straight-line ALU ops.
    run(16'h0412, 0, 0, 0, 0, 0, 1);
    run(16'h0300, 0, 0, 0, 0, 0, 1);
    chk("pin_seq_pc", int'(pc), 'h002);

    // Conditional jumps.
    run(16'h2955, 0, 0, 1, 0, 0, 1);
    chk("pin_jze_taken", int'(pc), 'h155);
    run(16'h2955, 0, 0, 0, 0, 0, 1);
    chk("pin_jze_not", int'(pc), 'h156);
    run(16'h2010, 0, 0, 0, 0, 0, 1);

    // Subroutine call/return.
    run(16'h1CFE, 0, 0, 0, 0, 0, 1);
    chk("pin_bsr_pc", int'(pc), 'h00E);
    run(16'h4100, 0, 0, 0, 0, 0, 1);
    chk("pin_ret_pc", int'(pc), 'h011);
    chk("pin_ret_err", int'(stk_err), 0);

    run(16'h3100, 0, 0, 0, 0, 0, 1);
    run(16'h3100, 0, 0, 0, 1, 0, 1);
    run(16'h3FFF, 0, 0, 0, 0, 1, 1);
    chk("pin_jcy_pc", int'(pc), 'h7FF);
    run(16'h3F00, 0, 0, 0, 0, 0, 1);
    chk("pin_wrap_pc", int'(pc), 'h000);
    // Control flow ignores decoder memory requests.
    run(16'h2000, 1, 1, 0, 0, 0, 1);

    // Stack overflow then underflow.
    for (int i = 0; i < 4; i++) run(16'h1C01, 0, 0, 0, 0, 0, 1);
    chk("pin_full_no_err", int'(stk_err), 0);
    run(16'h1C01, 0, 0, 0, 0, 0, 1);
    chk("pin_ovf_err", int'(stk_err), 1);
    chk("pin_ovf_pc", int'(pc), 'h005);
    for (int i = 0; i < 4; i++) run(16'h4100, 0, 0, 0, 0, 0, 1);
    chk("pin_pop_pc", int'(pc), 'h001);
    run(16'h4100, 0, 0, 0, 0, 0, 1);
    chk("pin_unf_pc", int'(pc), 'h002);
    chk("pin_unf_err", int'(stk_err), 1);

    // Memory reads/writes with wait states.
    run(16'h5007, 1, 0, 0, 0, 0, 3);
    run(16'h5107, 0, 1, 0, 0, 0, 3);
    run(16'h5007, 1, 0, 0, 0, 0, 1);
    run(16'h5107, 0, 1, 0, 0, 0, 1);
    run(16'h5207, 1, 1, 0, 0, 0, 2);
    chk("pin_mem_pc", int'(pc), 'h007);

    // Reset while a data transfer is outstanding.
    imem_data = 16'h5007; dec_mr = 1'b1; dec_mw = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = imem_req;
    end
    imem_ack = 1'b1;
    @(posedge clk);
    m_we = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (dmem_req) seen = 1'b1;
      else @(negedge clk);
    end
    chk("mid_mem_req_seen", int'(seen), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_drops_dmem_req", int'(dmem_req), 0);
    chk("rst_pc_mid", int'(pc), 0);
    m_pc = 0; m_err = 1'b0; m_stk.delete();
    dec_mr = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    run(16'h0412, 0, 0, 0, 0, 0, 1);
    chk("pin_after_rst_pc", int'(pc), 'h001);
    chk("pin_after_rst_err", int'(stk_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
